// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers, one-shot or
// auto-reload expiry, and an interrupt request gated by the CTRL mask bit.
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    logic [1:0]  state;
    logic [3:0]  ctrl;      // {IM, Mode[1:0], Enable}
    logic [31:0] preset;
    logic [31:0] count;
    logic        done;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        expire;
    logic        auto_reload;
    logic        unused_bits;

    assign unused_bits = ^{addr[31:4], addr[1:0]};

    always_comb begin
        wr_ctrl     = we && (addr[3:2] == 2'd0);
        wr_preset   = we && (addr[3:2] == 2'd1);
        auto_reload = (ctrl[2:1] == 2'd1);
        expire      = (state == S_CNT) && ctrl[0] && (count <= 32'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ctrl   <= 4'd0;
            preset <= 32'd0;
            count  <= 32'd0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (ctrl[0]) state <= S_LOAD;
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= 32'd0;
                        state <= S_INT;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A CPU write to CTRL overrides the one-shot Enable clear on the same edge.
            if (wr_ctrl)
                ctrl <= wdata[3:0];
            else if (state == S_INT && !auto_reload)
                ctrl[0] <= 1'b0;

            if (wr_preset)
                preset <= wdata;

            // Expiry takes priority over a coincident CPU clear so no event is lost.
            if (expire)
                done <= 1'b1;
            else if (wr_ctrl || wr_preset || (state == S_INT && auto_reload))
                done <= 1'b0;
        end
    end

    always_comb begin
        case (addr[3:2])
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = done & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed scenarios with literal expectations plus
// randomized register traffic compared every cycle against a behavioural model.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 1'b0;

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Reference model: timer run described as phases of a countdown run.
    typedef enum int {PH_STOPPED, PH_ARMED, PH_RUNNING, PH_EXPIRED} phase_t;
    phase_t      m_phase;
    logic [3:0]  m_ctrl;
    logic [31:0] m_pre;
    logic [31:0] m_cnt;
    logic        m_done;

    always @(posedge clk) begin
        bit          wc, wp, fire, clear;
        logic [3:0]  nc;
        logic [31:0] ncnt;
        phase_t      nph;
        if (reset) begin
            m_phase = PH_STOPPED; m_ctrl = 4'd0; m_pre = 32'd0;
            m_cnt = 32'd0; m_done = 1'b0;
        end else begin
            wc    = we && (addr[3:2] == 2'd0);
            wp    = we && (addr[3:2] == 2'd1);
            nc    = m_ctrl;
            ncnt  = m_cnt;
            nph   = m_phase;
            fire  = 1'b0;
            clear = wc || wp;
            if (m_phase == PH_STOPPED) begin
                if (m_ctrl[0]) nph = PH_ARMED;
            end else if (m_phase == PH_ARMED) begin
                ncnt = m_pre; nph = PH_RUNNING;
            end else if (m_phase == PH_RUNNING) begin
                if (!m_ctrl[0]) nph = PH_STOPPED;
                else if (m_cnt >= 2) ncnt = m_cnt - 1;
                else begin ncnt = 0; fire = 1'b1; nph = PH_EXPIRED; end
            end else begin
                nph = PH_STOPPED;
                if (m_ctrl[2:1] == 2'd1) clear = 1'b1;
                else nc[0] = 1'b0;
            end
            if (wc) nc = wdata[3:0];
            if (wp) m_pre = wdata;
            if (fire) m_done = 1'b1;
            else if (clear) m_done = 1'b0;
            m_ctrl = nc; m_cnt = ncnt; m_phase = nph;
        end
    end

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_pre;
            2'd2:    return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("model_rdata", rdata, m_read(addr[3:2]));
            check("model_irq", {31'd0, irq}, {31'd0, m_done & m_ctrl[3]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        #1;
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    int seq3[6] = '{3, 2, 1, 0, 0, 0};

    initial begin
        reset = 1'b1; addr = 32'd0; we = 1'b0; wdata = 32'd0;
        cyc(); cyc();
        started = 1'b1;
        reset = 1'b0;
        chk("rst_ctrl", 32'h0, 32'd0);
        chk("rst_preset", 32'h4, 32'd0);
        chk("rst_count", 32'h8, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // One-shot, N=5
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);
        cyc(); cyc();
        for (int k = 0; k < 6; k++) begin
            chk("oneshot_count", 32'h8, 32'(5 - k));
            chk_irq("oneshot_irq", k == 5);
            if (k < 5) cyc();
        end
        cyc();
        chk("oneshot_ctrl_after", 32'h0, 32'h8);
        chk_irq("oneshot_irq_held", 1'b1);
        cyc(); cyc(); cyc();
        chk_irq("oneshot_irq_held2", 1'b1);
        wr(32'h0, 32'h0);
        chk_irq("oneshot_irq_cleared", 1'b0);

        // Auto-reload, N=3
        do_reset();
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        cyc(); cyc();
        for (int k = 0; k < 18; k++) begin
            chk("reload_count", 32'h8, 32'(seq3[k % 6]));
            chk_irq("reload_irq", (k % 6) == 3);
            chk("reload_ctrl", 32'h0, 32'hB);
            cyc();
        end

        // Masked expiry: done set internally, irq stays low
        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h1);
        cyc(); cyc(); cyc(); cyc();
        chk("mask_count", 32'h8, 32'd0);
        chk_irq("mask_irq", 1'b0);
        check("mask_done", {31'd0, dut.done}, 32'd1);
        cyc(); cyc();
        chk("mask_ctrl", 32'h0, 32'h0);
        chk_irq("mask_irq2", 1'b0);

        // Abort mid-count, then re-enable reloads
        do_reset();
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h1);
        cyc(); cyc(); cyc(); cyc();
        chk("abort_count8", 32'h8, 32'd8);
        wr(32'h0, 32'h0);
        chk("abort_count7", 32'h8, 32'd7);
        cyc(); cyc(); cyc();
        chk("abort_frozen", 32'h8, 32'd7);
        wr(32'h0, 32'h1);
        cyc();
        chk("abort_still", 32'h8, 32'd7);
        cyc();
        chk("abort_reload", 32'h8, 32'd10);

        // Write edge cases
        do_reset();
        wr(32'h8, 32'h1234);
        chk("count_ro", 32'h8, 32'd0);
        wr(32'hC, 32'hFFFF_FFFF);
        chk("reserved_zero", 32'hC, 32'd0);
        wr(32'h0, 32'hFFFF_FFFF);
        chk("ctrl_mask", 32'h0, 32'hF);

        do_reset();
        wr(32'h4, 32'd4);
        wr(32'h0, 32'h1);
        cyc(); cyc();
        chk("midpre_count4", 32'h8, 32'd4);
        wr(32'h4, 32'd100);
        chk("midpre_count3", 32'h8, 32'd3);
        cyc(); cyc(); cyc();
        chk("midpre_count0", 32'h8, 32'd0);
        check("midpre_done", {31'd0, dut.done}, 32'd1);
        chk("midpre_preset", 32'h4, 32'd100);

        do_reset();
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h1);
        cyc(); cyc(); cyc(); cyc();
        wr(32'h0, 32'h1);
        chk("int_race_ctrl", 32'h0, 32'h1);
        cyc(); cyc();
        chk("int_race_reload", 32'h8, 32'd2);

        // Reset one cycle before expiry
        do_reset();
        wr(32'h4, 32'd3);
        wr(32'h0, 32'h9);
        cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk_irq("rstmid_irq", 1'b0);
        chk("rstmid_ctrl", 32'h0, 32'd0);
        chk("rstmid_count", 32'h8, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk_irq("rstmid_irq_later", 1'b0);
            cyc();
        end

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] sel;
            sel   = 2'($urandom);
            addr  = {28'($urandom), sel, 2'b00};
            reset = ($urandom_range(0, 299) == 0);
            we    = ($urandom_range(0, 9) == 0);
            if (sel == 2'd1) wdata = 32'($urandom_range(0, 7));
            else wdata = $urandom;
            cyc();
        end
        we = 1'b0; reset = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
